fifo_rd_ctrl: RTL

Burst read controller on the read side of the 256x8-to-128x16 dual-clock FIFO. Watches the FIFO read-side fill level and, once a full burst is buffered, drains exactly BURST_LEN 16-bit words into a valid/ready stream with a last marker. A 4-entry output buffer absorbs the FIFO's one-cycle read latency, so downstream backpressure never loses or reorders words.

---
 rtl/fifo_rd_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller for the read side of the dual-clock FIFO: waits for a full burst,
// then drains BURST_LEN words into a valid/ready stream. Define RD_CTRL_CNT_EN for burst_cnt.
module fifo_rd_ctrl #(
  parameter int BURST_LEN = 16
) (
  input  logic        rdclk,
  input  logic        sys_rst_n,
  input  logic        rdempty,
  input  logic        rdfull,
  input  logic [6:0]  rdusedw,
  input  logic [15:0] fifo_q,
  output logic        rdreq,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_last,
  input  logic        po_ready
`ifdef RD_CTRL_CNT_EN
  ,
  output logic [15:0] burst_cnt
`endif
);

  localparam logic [6:0] BURST_LEN_W = 7'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  iss_cnt_reg, iss_cnt_next;
  logic [2:0]  occ_reg;
  logic        inflight_reg;
  logic        inflight_last_reg;
  logic [1:0]  head_reg, tail_reg;
  logic [15:0] hold_reg;
  logic [15:0] buf_data [4];
  logic        buf_last [4];

  logic push, pop, credit_ok, issue_last;

  assign push      = inflight_reg;
  assign pop       = po_valid && po_ready;
  assign po_valid  = (occ_reg != 3'd0);
  // When empty, po_data keeps the most recently popped word rather than stale buffer contents.
  assign po_data   = po_valid ? buf_data[head_reg] : hold_reg;
  assign po_last   = po_valid && buf_last[head_reg];
  // Counting the in-flight read as occupied keeps occ at 3 or below.
  assign credit_ok = (({1'b0, occ_reg} + {3'b000, inflight_reg}) <= 4'd2);
  assign issue_last = rdreq && (iss_cnt_reg == BURST_LEN_W - 7'd1);

  always_comb begin
    state_next   = state_reg;
    iss_cnt_next = iss_cnt_reg;
    rdreq        = 1'b0;
    case (state_reg)
      IDLE: begin
        iss_cnt_next = 7'd0;
        if ((rdusedw >= BURST_LEN_W) || rdfull)
          state_next = BURST;
      end
      BURST: begin
        rdreq = !rdempty && credit_ok && (iss_cnt_reg < BURST_LEN_W);
        if (rdreq)
          iss_cnt_next = iss_cnt_reg + 7'd1;
        if (iss_cnt_next == BURST_LEN_W)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && po_last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rdclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg         <= IDLE;
      iss_cnt_reg       <= 7'd0;
      occ_reg           <= 3'd0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      head_reg          <= 2'd0;
      tail_reg          <= 2'd0;
      hold_reg          <= 16'h0000;
    end else begin
      state_reg         <= state_next;
      iss_cnt_reg       <= iss_cnt_next;
      inflight_reg      <= rdreq;
      inflight_last_reg <= issue_last;
      if (push)
        tail_reg <= tail_reg + 2'd1;
      if (pop) begin
        head_reg <= head_reg + 2'd1;
        hold_reg <= buf_data[head_reg];
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 3'd1;
        2'b01:   occ_reg <= occ_reg - 3'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Buffer storage needs no reset: occ_reg alone decides which entries are live.
  always_ff @(posedge rdclk) begin
    if (push) begin
      buf_data[tail_reg] <= fifo_q;
      buf_last[tail_reg] <= inflight_last_reg;
    end
  end

`ifdef RD_CTRL_CNT_EN
  logic [15:0] burst_cnt_reg;

  always_ff @(posedge rdclk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      burst_cnt_reg <= 16'h0000;
    else if (pop && po_last)
      burst_cnt_reg <= burst_cnt_reg + 16'h0001;
  end

  assign burst_cnt = burst_cnt_reg;
`endif

endmodule
